// File: rtl/ld_indirect_seq.sv
`default_nettype none
// =============================================================================
// Module   : ld_indirect_seq
// Brief    : Self-timed microcode sequencer for 8-bit LD (rr),A / LD (a16),A /
//            LDH (a8|C),A in both directions. Define LDIND_WAIT_EN to honour
//            i_Bus_Ready wait states.
// Revision : 1.0 - initial release
// =============================================================================
module ld_indirect_seq #(
    parameter int T_PER_M = 4,
    parameter int REG16_W = 6
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    input  logic               i_Start,
    input  logic [2:0]         i_Mode,
    input  logic [3:0]         i_P,
    input  logic               i_Dir,
    input  logic               i_Bus_Ready,
    output logic               o_Busy,
    output logic               o_Done,
    output logic               o_Error,
    output logic               o_IR_Fetch,
    output logic [REG16_W-1:0] o_Read16,
    output logic [REG16_W-1:0] o_Write16,
    output logic [1:0]         o_Increment16,
    output logic               o_Address_Out,
    output logic               o_High_Page,
    output logic [1:0]         o_Imm_Latch,
    output logic [1:0]         o_ReadALU8,
    output logic [1:0]         o_WriteALU8,
    output logic               o_Move_Reg,
    output logic               o_Bus_In,
    output logic               o_Bus_Out
);

    localparam int            TW     = (T_PER_M > 1) ? $clog2(T_PER_M) : 1;
    localparam logic [TW-1:0] T_ADDR = TW'(1);
    localparam logic [TW-1:0] T_XFER = TW'(T_PER_M - 1);

    localparam logic [REG16_W-1:0] C_SEL_PC = REG16_W'(1);
    localparam logic [REG16_W-1:0] C_SEL_BC = REG16_W'(2);
    localparam logic [REG16_W-1:0] C_SEL_DE = REG16_W'(4);
    localparam logic [REG16_W-1:0] C_SEL_HL = REG16_W'(8);
    localparam logic [REG16_W-1:0] C_SEL_WZ = REG16_W'(32);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_IMM_LO = 3'd1;
    localparam logic [2:0] S_IMM_HI = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_FETCH  = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [TW-1:0]      tcnt_q, tcnt_d;
    logic [1:0]         mode_q, mode_d;
    logic [3:0]         ptr_q, ptr_d;
    logic               dir_q, dir_d;
    logic               err_q, err_d;

    logic               w_ready;
    logic               w_ptr_onehot;
    logic               w_start_ok;
    logic               w_last_t;
    logic               w_bus_state;
    logic               w_xfer;
    logic               w_stall;
    logic [REG16_W-1:0] w_addr_sel;
    logic [REG16_W-1:0] w_wb_sel;
    logic [1:0]         w_inc;
    logic               w_hp;

`ifdef LDIND_WAIT_EN
    assign w_ready = i_Bus_Ready;
`else
    // Ready is forced high; the OR keeps the port referenced.
    assign w_ready = i_Bus_Ready | 1'b1;
`endif

    assign w_ptr_onehot = (i_P == 4'b0001) || (i_P == 4'b0010) ||
                          (i_P == 4'b0100) || (i_P == 4'b1000);
    assign w_start_ok   = !i_Mode[2] && ((i_Mode[1:0] != 2'd0) || w_ptr_onehot);
    assign w_last_t     = (tcnt_q == T_XFER);
    assign w_bus_state  = (state_q == S_IMM_LO) || (state_q == S_IMM_HI) ||
                          (state_q == S_MEM);
    assign w_xfer       = w_bus_state && w_last_t;
    assign w_stall      = w_xfer && !w_ready;

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        mode_d  = mode_q;
        ptr_d   = ptr_q;
        dir_d   = dir_q;
        err_d   = 1'b0;
        if (state_q == S_IDLE) begin
            if (i_Start) begin
                if (w_start_ok) begin
                    mode_d  = i_Mode[1:0];
                    ptr_d   = i_P;
                    dir_d   = i_Dir;
                    tcnt_d  = '0;
                    state_d = ((i_Mode[1:0] == 2'd1) || (i_Mode[1:0] == 2'd2))
                              ? S_IMM_LO : S_MEM;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else if (!w_stall) begin
            if (w_last_t) begin
                tcnt_d = '0;
                case (state_q)
                    S_IMM_LO: state_d = (mode_q == 2'd1) ? S_IMM_HI : S_MEM;
                    S_IMM_HI: state_d = S_MEM;
                    S_MEM:    state_d = S_FETCH;
                    default:  state_d = S_IDLE;
                endcase
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end
        end
    end

    // Address source for the current M-cycle; reused while a transfer waits.
    always_comb begin
        w_addr_sel = C_SEL_PC;
        w_wb_sel   = '0;
        w_inc      = 2'b01;
        w_hp       = 1'b0;
        if (state_q == S_MEM) begin
            w_inc = 2'b00;
            case (mode_q)
                2'd0: begin
                    if (ptr_q[0]) begin
                        w_addr_sel = C_SEL_BC;
                    end else if (ptr_q[1]) begin
                        w_addr_sel = C_SEL_DE;
                    end else begin
                        w_addr_sel = C_SEL_HL;
                        w_wb_sel   = C_SEL_HL;
                        w_inc      = {ptr_q[3], 1'b1};
                    end
                end
                2'd1: w_addr_sel = C_SEL_WZ;
                2'd2: begin
                    w_addr_sel = C_SEL_WZ;
                    w_hp       = 1'b1;
                end
                default: begin
                    w_addr_sel = C_SEL_BC;
                    w_hp       = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        o_Busy        = (state_q != S_IDLE);
        o_Done        = 1'b0;
        o_IR_Fetch    = 1'b0;
        o_Read16      = '0;
        o_Write16     = '0;
        o_Increment16 = 2'b00;
        o_Address_Out = 1'b0;
        o_High_Page   = 1'b0;
        o_Imm_Latch   = 2'b00;
        o_ReadALU8    = 2'b00;
        o_WriteALU8   = 2'b00;
        o_Move_Reg    = 1'b0;
        o_Bus_In      = 1'b0;
        o_Bus_Out     = 1'b0;
        if (state_q == S_FETCH) begin
            o_IR_Fetch = 1'b1;
            o_Done     = w_last_t;
        end else if (w_bus_state) begin
            if (tcnt_q == T_ADDR) begin
                o_Read16      = w_addr_sel;
                o_Address_Out = 1'b1;
                o_High_Page   = w_hp;
                o_Write16     = w_wb_sel;
                o_Increment16 = w_inc;
            end else if (w_stall) begin
                o_Read16      = w_addr_sel;
                o_Address_Out = 1'b1;
                o_High_Page   = w_hp;
            end else if (w_xfer) begin
                // In LDH a8 only Z is latched; W is irrelevant under High_Page.
                case (state_q)
                    S_IMM_LO: begin
                        o_Bus_In    = 1'b1;
                        o_Imm_Latch = 2'b01;
                    end
                    S_IMM_HI: begin
                        o_Bus_In    = 1'b1;
                        o_Imm_Latch = 2'b10;
                    end
                    default: begin
                        if (dir_q) begin
                            o_WriteALU8 = 2'b01;
                            o_Bus_In    = 1'b1;
                        end else begin
                            o_ReadALU8  = 2'b01;
                            o_Move_Reg  = 1'b1;
                            o_Bus_Out   = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign o_Error = err_q;

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= S_IDLE;
            tcnt_q  <= '0;
            mode_q  <= 2'd0;
            ptr_q   <= 4'd0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            mode_q  <= mode_d;
            ptr_q   <= ptr_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ld_indirect_seq.sv
`default_nettype none
// tb_ld_indirect_seq: cycle-list model of each load/store sequence compared
// against ld_indirect_seq every cycle, plus literal pins from the test plan.
module tb_ld_indirect_seq;

    localparam int T = 4;
`ifdef LDIND_WAIT_EN
    localparam int WAIT_EN = 1;
`else
    localparam int WAIT_EN = 0;
`endif

    localparam int K_IMM_LO = 0;
    localparam int K_IMM_HI = 1;
    localparam int K_MEM    = 2;
    localparam int K_FETCH  = 3;

    typedef struct packed {
        logic       err;
        logic       busy;
        logic       done;
        logic       irf;
        logic [5:0] r16;
        logic [5:0] w16;
        logic [1:0] inc;
        logic       addr;
        logic       hp;
        logic [1:0] imm;
        logic [1:0] ralu;
        logic [1:0] walu;
        logic       mv;
        logic       bin;
        logic       bout;
    } ov_t;

    logic       clk = 1'b0;
    logic       rst, start, dir, ready;
    logic [2:0] mode;
    logic [3:0] p;
    logic       busy, done, err, irf, addr, hp, mv, bin, bout;
    logic [5:0] r16, w16;
    logic [1:0] inc, imm, ralu, walu;

    ld_indirect_seq #(.T_PER_M(T), .REG16_W(6)) dut (
        .i_Clk(clk), .i_Reset(rst), .i_Start(start), .i_Mode(mode), .i_P(p),
        .i_Dir(dir), .i_Bus_Ready(ready), .o_Busy(busy), .o_Done(done),
        .o_Error(err), .o_IR_Fetch(irf), .o_Read16(r16), .o_Write16(w16),
        .o_Increment16(inc), .o_Address_Out(addr), .o_High_Page(hp),
        .o_Imm_Latch(imm), .o_ReadALU8(ralu), .o_WriteALU8(walu),
        .o_Move_Reg(mv), .o_Bus_In(bin), .o_Bus_Out(bout)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_fail   = 0;
    ov_t   exp_q[$];
    ov_t   rec[$];
    string cur_name = "none";

    function automatic ov_t dut_vec();
        ov_t v;
        v = {err, busy, done, irf, r16, w16, inc, addr, hp, imm, ralu, walu, mv, bin, bout};
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ov_t e;
            ov_t a;
            e = exp_q.pop_front();
            a = dut_vec();
            rec.push_back(a);
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s busy-cycle %0d: got %h expected %h",
                         cur_name, rec.size() - 2, a, e);
            end
        end
    end

    // Address-phase outputs of an M-cycle, straight from the instruction table.
    function automatic ov_t addr_phase(input int k, input int md, input logic [3:0] pp);
        ov_t v;
        v = '0;
        v.busy = 1'b1;
        v.addr = 1'b1;
        if (k == K_IMM_LO || k == K_IMM_HI) begin
            v.r16 = 6'b000001;
            v.inc = 2'b01;
        end else begin
            case (md)
                0: begin
                    if (pp == 4'b0001)      v.r16 = 6'b000010;
                    else if (pp == 4'b0010) v.r16 = 6'b000100;
                    else begin
                        v.r16 = 6'b001000;
                        v.w16 = 6'b001000;
                        v.inc = (pp == 4'b1000) ? 2'b11 : 2'b01;
                    end
                end
                1: v.r16 = 6'b100000;
                2: begin v.r16 = 6'b100000; v.hp = 1'b1; end
                default: begin v.r16 = 6'b000010; v.hp = 1'b1; end
            endcase
        end
        return v;
    endfunction

    function automatic ov_t xfer(input int k, input logic d);
        ov_t v;
        v = '0;
        v.busy = 1'b1;
        if (k == K_IMM_LO) begin v.bin = 1'b1; v.imm = 2'b01; end
        else if (k == K_IMM_HI) begin v.bin = 1'b1; v.imm = 2'b10; end
        else if (d) begin v.walu = 2'b01; v.bin = 1'b1; end
        else begin v.ralu = 2'b01; v.mv = 1'b1; v.bout = 1'b1; end
        return v;
    endfunction

    // Expected outputs from the start cycle to the last busy cycle.
    task automatic build(input int md, input logic [3:0] pp, input logic d, input int waits);
        int  ks[$];
        ov_t v;
        exp_q.push_back(ov_t'(0));
        if (md >= 4 || (md == 0 && $countones(pp) != 1)) begin
            v = '0;
            v.err = 1'b1;
            exp_q.push_back(v);
            return;
        end
        case (md)
            1:       ks = '{K_IMM_LO, K_IMM_HI, K_MEM};
            2:       ks = '{K_IMM_LO, K_MEM};
            default: ks = '{K_MEM};
        endcase
        ks.push_back(K_FETCH);
        foreach (ks[i]) begin
            for (int t = 0; t < T; t++) begin
                if (ks[i] == K_FETCH) begin
                    v = '0;
                    v.busy = 1'b1;
                    v.irf  = 1'b1;
                    v.done = (t == T - 1);
                    exp_q.push_back(v);
                end else if (t == 1) begin
                    exp_q.push_back(addr_phase(ks[i], md, pp));
                end else if (t == T - 1) begin
                    if (ks[i] == K_MEM) begin
                        for (int w = 0; w < waits * WAIT_EN; w++) begin
                            v = addr_phase(ks[i], md, pp);
                            v.inc = 2'b00;
                            v.w16 = 6'b0;
                            exp_q.push_back(v);
                        end
                    end
                    exp_q.push_back(xfer(ks[i], d));
                end else begin
                    v = '0;
                    v.busy = 1'b1;
                    exp_q.push_back(v);
                end
            end
        end
    endtask

    // ws/wn: ready low for wn busy cycles from busy cycle ws. poke: start while busy.
    task automatic run_seq(input string nm, input int md, input logic [3:0] pp, input logic d,
                           input int ws, input int wn, input bit poke);
        int c;
        @(posedge clk); #1;
        cur_name = nm;
        rec.delete();
        start = 1'b1; mode = md[2:0]; p = pp; dir = d; ready = 1'b1;
        build(md, pp, d, wn);
        c = 0;
        while (exp_q.size() > 1 && c < 300) begin
            @(posedge clk); #1;
            start = poke && (c == 2);
            if (poke && c == 2) mode = 3'd5;
            ready = !(c >= ws && c < ws + wn);
            c++;
        end
        @(negedge clk); #1;
        start = 1'b0; ready = 1'b1;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: got %0d pending expected 0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int off;
        rst = 1'b1; start = 1'b0; mode = 3'd0; p = 4'd0; dir = 1'b0; ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", dut_vec(), 0);
        rst = 1'b0;

        run_seq("m0_bc_store", 0, 4'b0001, 1'b0, 99, 0, 1'b0);
        check("m0_bc_r16_c1", rec[2].r16, 6'b000010);
        check("m0_bc_addr_c1", rec[2].addr, 1);
        check("m0_bc_bout_c3", {rec[4].bout, rec[4].mv, rec[4].ralu}, 4'b1101);
        check("m0_bc_irf_c4_7", {rec[5].irf, rec[6].irf, rec[7].irf, rec[8].irf}, 4'b1111);
        check("m0_bc_done_c7", {rec[7].done, rec[8].done}, 2'b01);

        run_seq("m0_hlm_load", 0, 4'b1000, 1'b1, 99, 0, 1'b0);
        check("m0_hlm_w16_c1", rec[2].w16, 6'b001000);
        check("m0_hlm_inc_c1", rec[2].inc, 2'b11);
        check("m0_hlm_walu_c3", {rec[4].walu, rec[4].bin}, 3'b011);

        run_seq("m0_de_store_poke", 0, 4'b0010, 1'b0, 99, 0, 1'b1);
        run_seq("m0_hlp_load", 0, 4'b0100, 1'b1, 99, 0, 1'b0);

        run_seq("m1_load", 1, 4'b0000, 1'b1, 99, 0, 1'b0);
        check("m1_imm_c3", rec[4].imm, 2'b01);
        check("m1_imm_c7", rec[8].imm, 2'b10);
        check("m1_r16_c9", rec[10].r16, 6'b100000);
        check("m1_done_c15", rec[16].done, 1);

        run_seq("m2_wait_load", 2, 4'b0000, 1'b1, 7, 3, 1'b0);
        off = 3 * WAIT_EN;
        check("m2_walu_xfer", rec[8 + off].walu, 2'b01);
        check("m2_done", rec[12 + off].done, 1);
        check("m2_hp_c5", rec[6].hp, 1);

        run_seq("m3_store", 3, 4'b0000, 1'b0, 99, 0, 1'b0);
        check("m3_r16_c1", {rec[2].r16, rec[2].hp}, 7'b0000101);
        run_seq("m1_store", 1, 4'b0000, 1'b0, 99, 0, 1'b0);
        run_seq("m2_store", 2, 4'b0000, 1'b0, 99, 0, 1'b0);

        run_seq("rej_mode5", 5, 4'b0001, 1'b0, 99, 0, 1'b0);
        check("rej_mode5_err", {rec[1].err, rec[1].busy}, 2'b10);
        run_seq("rej_p0011", 0, 4'b0011, 1'b0, 99, 0, 1'b0);
        check("rej_p0011_err", {rec[1].err, rec[1].busy}, 2'b10);
        run_seq("after_reject", 3, 4'b0000, 1'b1, 99, 0, 1'b0);

        // Reset at busy cycle 2 of a mode-1 load.
        @(posedge clk); #1;
        cur_name = "reset_mid";
        start = 1'b1; mode = 3'd1; p = 4'd0; dir = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("rstmid_busy_c0", busy, 1);
        @(posedge clk); #1;
        check("rstmid_r16_c1", {r16, addr}, 7'b0000011);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rstmid_async_zero", dut_vec(), 0);
        @(posedge clk); #1;
        check("rstmid_hold_zero", dut_vec(), 0);
        rst = 1'b0;
        run_seq("m1_after_reset", 1, 4'b0000, 1'b1, 99, 0, 1'b0);
        check("m1r_done_c15", {rec[16].done, rec[16].busy}, 2'b11);
        check("m1r_len", rec.size(), 17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
